// File: rtl/vga_scan_engine.sv
// VGA scan generator: h/v counters, sync/blank timing, framebuffer address
// generation with integer pixel replication, frame-synchronous base switching,
// and a delay pipeline that lines sync/enable up with the returned pixel data.
module vga_scan_engine #(
    parameter int WIDTH      = 12,
    parameter int HSIZE      = 800,
    parameter int HFP        = 856,
    parameter int HSP        = 976,
    parameter int HMAX       = 1040,
    parameter int VSIZE      = 600,
    parameter int VFP        = 637,
    parameter int VSP        = 643,
    parameter int VMAX       = 666,
    parameter int HSPP       = 1,
    parameter int VSPP       = 1,
    parameter int SCALE_LOG2 = 0,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] fb_base,
    output logic                  fb_rd_en,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data,
    output logic [WIDTH-1:0]      hdata,
    output logic [WIDTH-1:0]      vdata,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  data_enable,
    output logic [7:0]            red,
    output logic [7:0]            green,
    output logic [7:0]            blue,
    output logic                  frame_start
);

    // Total delay from counter value to colour output: address register,
    // memory latency, colour register.
    localparam int L = RD_LATENCY + 2;

    localparam logic [WIDTH-1:0] HSIZE_W = WIDTH'(HSIZE);
    localparam logic [WIDTH-1:0] HFP_W   = WIDTH'(HFP);
    localparam logic [WIDTH-1:0] HSP_W   = WIDTH'(HSP);
    localparam logic [WIDTH-1:0] HLAST_W = WIDTH'(HMAX - 1);
    localparam logic [WIDTH-1:0] VSIZE_W = WIDTH'(VSIZE);
    localparam logic [WIDTH-1:0] VFP_W   = WIDTH'(VFP);
    localparam logic [WIDTH-1:0] VSP_W   = WIDTH'(VSP);
    localparam logic [WIDTH-1:0] VLAST_W = WIDTH'(VMAX - 1);

    // Low vdata bits that must be zero for a line to start a new source row.
    localparam logic [WIDTH-1:0]      SMASK    = WIDTH'((1 << SCALE_LOG2) - 1);
    // Framebuffer words per source row.
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(HSIZE >> SCALE_LOG2);

    localparam logic HS_ON = (HSPP != 0);
    localparam logic VS_ON = (VSPP != 0);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } timing_t;

    localparam timing_t STAGE_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, de: 1'b0};

    logic [WIDTH-1:0]      hdata_reg, hdata_next;
    logic [WIDTH-1:0]      vdata_reg, vdata_next;
    logic [ADDR_WIDTH-1:0] row_off_reg, row_off_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;
    logic [ADDR_WIDTH-1:0] address_reg, address_next;
    logic                  rd_en_reg;
    logic [23:0]           rgb_reg;
    logic                  h_last;
    logic                  v_last;
    logic                  vis;
    timing_t               raw_timing;
    logic [7:0]            pad_unused;

    assign pad_unused = data[31:24];

    assign h_last = (hdata_reg == HLAST_W);
    assign v_last = (vdata_reg == VLAST_W);
    assign vis    = (hdata_reg < HSIZE_W) && (vdata_reg < VSIZE_W);

    // Counter advance, incremental row offset and frame-boundary base latch.
    always_comb begin
        hdata_next   = hdata_reg + 1'b1;
        vdata_next   = vdata_reg;
        row_off_next = row_off_reg;
        base_next    = base_reg;
        if (h_last) begin
            hdata_next = '0;
            if (v_last) begin
                vdata_next   = '0;
                row_off_next = '0;
                base_next    = fb_base;
            end else begin
                vdata_next = vdata_reg + 1'b1;
                if ((vdata_next & SMASK) == '0) begin
                    row_off_next = row_off_reg + ROW_STEP;
                end
            end
        end
    end

    // Word address for the current counter position; zero outside the visible area.
    always_comb begin
        address_next = '0;
        if (vis) begin
            address_next = base_reg + row_off_reg + ADDR_WIDTH'(hdata_reg >> SCALE_LOG2);
        end
    end

    // Raw sync/enable derived directly from the counters.
    always_comb begin
        raw_timing.hs = ((hdata_reg >= HFP_W) && (hdata_reg < HSP_W)) ? HS_ON : ~HS_ON;
        raw_timing.vs = ((vdata_reg >= VFP_W) && (vdata_reg < VSP_W)) ? VS_ON : ~VS_ON;
        raw_timing.de = vis;
    end

    // Scan state and registered framebuffer request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdata_reg   <= '0;
            vdata_reg   <= '0;
            row_off_reg <= '0;
            base_reg    <= '0;
            address_reg <= '0;
            rd_en_reg   <= 1'b0;
        end else begin
            hdata_reg   <= hdata_next;
            vdata_reg   <= vdata_next;
            row_off_reg <= row_off_next;
            base_reg    <= base_next;
            address_reg <= address_next;
            rd_en_reg   <= vis;
        end
    end

    // Timing delay line, one stage per generate iteration.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_stage
            timing_t stage_reg;
            timing_t stage_d;
            if (gi == 0) begin : g_head
                assign stage_d = raw_timing;
            end else begin : g_tail
                assign stage_d = g_stage[gi-1].stage_reg;
            end
            // Advance this stage by one clock.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= STAGE_IDLE;
                end else begin
                    stage_reg <= stage_d;
                end
            end
        end
    endgenerate

    // Colour register: capture returned data only for visible pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_reg <= '0;
        end else if (g_stage[L-2].stage_reg.de) begin
            rgb_reg <= data[23:0];
        end else begin
            rgb_reg <= '0;
        end
    end

    assign hdata       = hdata_reg;
    assign vdata       = vdata_reg;
    assign fb_rd_en    = rd_en_reg;
    assign address     = address_reg;
    assign hsync       = g_stage[L-1].stage_reg.hs;
    assign vsync       = g_stage[L-1].stage_reg.vs;
    assign data_enable = g_stage[L-1].stage_reg.de;
    assign red         = rgb_reg[23:16];
    assign green       = rgb_reg[15:8];
    assign blue        = rgb_reg[7:0];
    assign frame_start = rst_n && (hdata_reg == '0) && (vdata_reg == '0);

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine using two small-timing instances:
// A (no scaling, RD_LATENCY=2, positive syncs) and B (2x scaling,
// RD_LATENCY=1, negative hsync). Both share clock and reset.
module tb_vga_scan_engine;

    logic        clk;
    logic        rst_n;
    logic [19:0] fb_base_a;
    logic [19:0] fb_base_b;

    logic        rd_en_a, rd_en_b;
    logic [19:0] address_a, address_b;
    logic [31:0] data_a, data_b;
    logic [11:0] hdata_a, vdata_a, hdata_b, vdata_b;
    logic        hsync_a, vsync_a, de_a, fs_a;
    logic        hsync_b, vsync_b, de_b, fs_b;
    logic [7:0]  red_a, green_a, blue_a;
    logic [7:0]  red_b, green_b, blue_b;

    int n_checks = 0;
    int n_fail   = 0;

    vga_scan_engine #(
        .WIDTH(12), .HSIZE(8), .HFP(10), .HSP(12), .HMAX(14),
        .VSIZE(4), .VFP(5), .VSP(6), .VMAX(7), .HSPP(1), .VSPP(1),
        .SCALE_LOG2(0), .RD_LATENCY(2), .ADDR_WIDTH(20)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .fb_base(fb_base_a), .fb_rd_en(rd_en_a),
        .address(address_a), .data(data_a), .hdata(hdata_a), .vdata(vdata_a),
        .hsync(hsync_a), .vsync(vsync_a), .data_enable(de_a),
        .red(red_a), .green(green_a), .blue(blue_a), .frame_start(fs_a)
    );

    vga_scan_engine #(
        .WIDTH(12), .HSIZE(8), .HFP(10), .HSP(12), .HMAX(14),
        .VSIZE(4), .VFP(5), .VSP(6), .VMAX(7), .HSPP(0), .VSPP(1),
        .SCALE_LOG2(1), .RD_LATENCY(1), .ADDR_WIDTH(20)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .fb_base(fb_base_b), .fb_rd_en(rd_en_b),
        .address(address_b), .data(data_b), .hdata(hdata_b), .vdata(vdata_b),
        .hsync(hsync_b), .vsync(vsync_b), .data_enable(de_b),
        .red(red_b), .green(green_b), .blue(blue_b), .frame_start(fs_b)
    );

    // Memory models returning data = address after the configured latency.
    logic [19:0] mem_a0 = '0;
    logic [19:0] mem_a1 = '0;
    logic [19:0] mem_b0 = '0;
    always @(posedge clk) begin
        mem_a0 <= address_a;
        mem_a1 <= mem_a0;
        mem_b0 <= address_b;
    end
    assign data_a = {12'h0, mem_a1};
    assign data_b = {12'h0, mem_b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s got=%0h exp=%0h", $time, tag, got, exp);
        end else begin
            $display("[%0t] ok   %s got=%0h", $time, tag, got);
        end
    endtask

    // Advance to the negedge where DUT A counters equal (h,v), bounded.
    task automatic wait_pos(input int h, input int v);
        int budget;
        budget = 200;
        @(negedge clk);
        while (!(hdata_a == 12'(h) && vdata_a == 12'(v)) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val($sformatf("reach_%0d_%0d", h, v), 32'(budget > 0), 32'd1);
    endtask

    initial begin : stim
        int rd_cnt [7];
        int hs_cnt_a, vs_cnt_a, hs_cnt_b, vs_cnt_b, rd_tot_b;
        for (int i = 0; i < 7; i++) rd_cnt[i] = 0;
        hs_cnt_a = 0; vs_cnt_a = 0; hs_cnt_b = 0; vs_cnt_b = 0; rd_tot_b = 0;

        rst_n     = 1'b0;
        fb_base_a = 20'h100;
        fb_base_b = 20'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check_val("rst_hdata", 32'(hdata_a), 32'd0);
        check_val("rst_vdata", 32'(vdata_a), 32'd0);
        check_val("rst_addr", 32'(address_a), 32'd0);
        check_val("rst_rd_en", 32'(rd_en_a), 32'd0);
        check_val("rst_hsync_a", 32'(hsync_a), 32'd0);
        check_val("rst_vsync_a", 32'(vsync_a), 32'd0);
        check_val("rst_de", 32'(de_a), 32'd0);
        check_val("rst_rgb", {8'h0, red_a, green_a, blue_a}, 32'd0);
        check_val("rst_frame_start", 32'(fs_a), 32'd0);
        check_val("rst_hsync_b", 32'(hsync_b), 32'd1);

        rst_n = 1'b1;
        #1;
        check_val("rel_frame_start", 32'(fs_a), 32'd1);

        // First frame (base 0) plus pipeline tail: per-line read counts and sync widths.
        for (int k = 1; k <= 102; k++) begin
            @(negedge clk);
            if (k <= 98) begin
                if (rd_en_a) rd_cnt[(k - 1) / 14]++;
                if (rd_en_b) rd_tot_b++;
            end
            if (k >= 5) begin
                hs_cnt_a += int'(hsync_a);
                vs_cnt_a += int'(vsync_a);
            end
            if (k >= 4 && k <= 101) begin
                hs_cnt_b += int'(!hsync_b);
                vs_cnt_b += int'(vsync_b);
            end
            if (k == 1) check_val("f1_addr_0_0", 32'(address_a), 32'd0);
            if (k == 20) check_val("f1_addr_5_1", 32'(address_a), 32'd13);
        end
        for (int i = 0; i < 7; i++)
            check_val($sformatf("rd_en_line%0d", i), 32'(rd_cnt[i]), (i < 4) ? 32'd8 : 32'd0);
        check_val("hsync_a_clocks", 32'(hs_cnt_a), 32'd14);
        check_val("vsync_a_clocks", 32'(vs_cnt_a), 32'd14);
        check_val("hsync_b_low_clocks", 32'(hs_cnt_b), 32'd14);
        check_val("vsync_b_clocks", 32'(vs_cnt_b), 32'd14);
        check_val("rd_en_b_total", 32'(rd_tot_b), 32'd32);

        // Second frame: base 0x100 active; change fb_base mid-frame.
        wait_pos(0, 1);
        fb_base_a = 20'h200;
        wait_pos(4, 1);
        @(negedge clk);
        check_val("b_addr_4_1", 32'(address_b), 32'd2);

        wait_pos(3, 2);
        @(negedge clk);
        check_val("a_addr_3_2", 32'(address_a), 32'h113);
        check_val("a_rd_en_3_2", 32'(rd_en_a), 32'd1);
        @(negedge clk);
        check_val("b_addr_4_2", 32'(address_b), 32'd6);
        repeat (2) @(negedge clk);
        check_val("a_de_3_2", 32'(de_a), 32'd1);
        check_val("a_red_3_2", 32'(red_a), 32'h00);
        check_val("a_green_3_2", 32'(green_a), 32'h01);
        check_val("a_blue_3_2", 32'(blue_a), 32'h13);

        wait_pos(4, 3);
        @(negedge clk);
        check_val("b_addr_4_3", 32'(address_b), 32'd6);
        @(negedge clk);
        check_val("b_addr_5_3", 32'(address_b), 32'd6);
        @(negedge clk);
        check_val("b_addr_6_3", 32'(address_b), 32'd7);
        @(negedge clk);
        check_val("b_de_5_3", 32'(de_b), 32'd1);
        check_val("b_blue_5_3", 32'(blue_b), 32'd6);

        // Sync edges after the pipeline delay.
        wait_pos(9, 3);
        repeat (3) @(negedge clk);
        check_val("b_hsync_9_3", 32'(hsync_b), 32'd1);
        @(negedge clk);
        check_val("a_hsync_9_3", 32'(hsync_a), 32'd0);
        check_val("b_hsync_10_3", 32'(hsync_b), 32'd0);
        @(negedge clk);
        check_val("a_hsync_10_3", 32'(hsync_a), 32'd1);

        wait_pos(13, 4);
        repeat (4) @(negedge clk);
        check_val("a_vsync_13_4", 32'(vsync_a), 32'd0);
        @(negedge clk);
        check_val("a_vsync_0_5", 32'(vsync_a), 32'd1);

        // Third frame picks up the new base.
        wait_pos(0, 0);
        check_val("f3_frame_start", 32'(fs_a), 32'd1);
        @(negedge clk);
        check_val("f3_addr_0_0", 32'(address_a), 32'h200);
        check_val("f3_rd_en_0_0", 32'(rd_en_a), 32'd1);
        check_val("f3_frame_start_off", 32'(fs_a), 32'd0);

        // Mid-frame reset.
        wait_pos(4, 1);
        rst_n = 1'b0;
        #1;
        check_val("mrst_hdata", 32'(hdata_a), 32'd0);
        check_val("mrst_vdata", 32'(vdata_a), 32'd0);
        check_val("mrst_addr", 32'(address_a), 32'd0);
        check_val("mrst_rd_en", 32'(rd_en_a), 32'd0);
        check_val("mrst_de", 32'(de_a), 32'd0);
        check_val("mrst_blue", 32'(blue_a), 32'd0);
        check_val("mrst_frame_start", 32'(fs_a), 32'd0);
        check_val("mrst_hsync_b", 32'(hsync_b), 32'd1);
        repeat (3) @(negedge clk);
        check_val("mrst_hold_hdata", 32'(hdata_a), 32'd0);
        rst_n = 1'b1;
        #1;
        check_val("mrel_frame_start", 32'(fs_a), 32'd1);
        @(negedge clk);
        check_val("mrel_addr", 32'(address_a), 32'd0);
        check_val("mrel_rd_en", 32'(rd_en_a), 32'd1);
        check_val("mrel_hdata", 32'(hdata_a), 32'd1);
        repeat (2) @(negedge clk);
        check_val("mrel_no_partial_de", 32'(de_a), 32'd0);
        @(negedge clk);
        check_val("mrel_first_de", 32'(de_a), 32'd1);
        check_val("mrel_first_blue", 32'(blue_a), 32'd0);
        @(negedge clk);
        check_val("mrel_second_blue", 32'(blue_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
Parametrised VGA scan generator with framebuffer read interface. It generates the h/v counters and sync/blank timing, and issues framebuffer word addresses with optional integer pixel replication (scaling). It also supports double-buffered base switching at frame boundaries. Returned pixel data goes through a read-latency-matched pipeline, so RGB, sync and data_enable leave the block cycle-aligned. It sits between the framebuffer RAM and the video DAC/HDMI encoder.

Parameters:
WIDTH, 12, bit width of hdata/vdata counters
HSIZE, 800, visible pixels per line
HFP, 856, hsync pulse start (hdata value)
HSP, 976, hsync pulse end (exclusive)
HMAX, 1040, total clocks per line
VSIZE, 600, visible lines
VFP, 637, vsync pulse start
VSP, 643, vsync pulse end (exclusive)
VMAX, 666, total lines per frame
HSPP, 1, hsync active polarity (1 positive, 0 negative)
VSPP, 1, vsync active polarity
SCALE_LOG2, 0, each framebuffer pixel is replicated 2^SCALE_LOG2 times horizontally and vertically; HSIZE and VSIZE are multiples of 2^SCALE_LOG2
RD_LATENCY, 1, framebuffer clocks from address to valid data, range 1..8
ADDR_WIDTH, 20, framebuffer address width

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
fb_base  in  ADDR_WIDTH  framebuffer base for the next frame
fb_rd_en  out  1  address valid (current counter position visible)
address  out  ADDR_WIDTH  framebuffer word address
data  in  32  framebuffer word, {8'x, R[23:16], G[15:8], B[7:0]}, valid RD_LATENCY clocks after address
hdata  out  WIDTH  current horizontal counter
vdata  out  WIDTH  current vertical counter
hsync  out  1  aligned horizontal sync
vsync  out  1  aligned vertical sync
data_enable  out  1  aligned visible-pixel flag
red  out  8  aligned red
green  out  8  aligned green
blue  out  8  aligned blue
frame_start  out  1  one-clock pulse when counters are at (0,0)

Behaviour:
- Reset (async, rst_n=0): hdata=vdata=0; address=0; fb_rd_en=0; active base=0; all delay stages cleared to inactive. Outputs during reset: hsync=!HSPP, vsync=!VSPP, data_enable=0, rgb=0, frame_start=0.
- Release: counting starts on the first clk edge with rst_n=1. The first frame uses base 0.
- Counters:
  - hdata increments each clock and wraps HMAX-1 -> 0.
  - vdata increments on the h wrap and wraps VMAX-1 -> 0 when h and v wrap together.
- Base latch: fb_base is sampled into the active base on the clock where hdata=HMAX-1 and vdata=VMAX-1. A change at any other time has no effect until the next frame.
- Visible: vis = (hdata<HSIZE)&&(vdata<VSIZE), evaluated on the counter values.
- fb_rd_en and address are registered, one clock after the counter value they describe. In that clock:
  - fb_rd_en = vis;
  - address = base + (vdata>>S)*(HSIZE>>S) + (hdata>>S);
  - address = 0 when not visible.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - The row offset is computed incrementally (add HSIZE>>S at each line start where vdata[S-1:0]==0 and vdata!=0). No multiplier.
- Raw timing from counters:
  - hs = HSPP when HFP<=hdata<HSP, else !HSPP;
  - vs likewise with VFP/VSP/VSPP;
  - de = vis.
- Alignment: hs, vs and de go through a shift register of depth L = RD_LATENCY+2. This covers 1 address register, RD_LATENCY of memory, and 1 output register.
- Colour output: red/green/blue are registered from data when the delayed de is 1, and forced to 0 otherwise. Pixel at counter (h,v) appears on red/green/blue/data_enable exactly L clocks after hdata=h, vdata=v.
- frame_start: combinational pulse when hdata==0 && vdata==0. It is not delayed and not asserted during reset.
- Reset mid-frame: counters, pipeline and base return to reset values immediately. No partial pixel emerges after reset is released.

Test Plan:
- Small params HSIZE=8,HFP=10,HSP=12,HMAX=14,VSIZE=4,VFP=5,VSP=6,VMAX=7,RD_LATENCY=2,S=0, fb_base=0x100 latched -> second frame: address for (h=3,v=2) = 0x113. fb_rd_en is high for exactly 8 clocks per visible line and low for lines 4..6.
- Same params, memory model returns data = address -> red/green/blue for (3,2) appear 4 clocks after counter (3,2), with blue=0x13, green=0x01. data_enable, hsync and vsync are shifted by the same 4 clocks.
- SCALE_LOG2=1, base 0 -> (h=5,v=3) gives address 6. Each address repeats on 2 consecutive clocks and on 2 consecutive lines.
- HSPP=0,VSPP=1 -> hsync low for exactly 2 clocks per line; vsync high for exactly 1 line per frame (lines 5..5, delayed by L).
- Change fb_base mid-frame from 0x100 to 0x200 -> the remaining lines still use 0x100; the next frame's pixel (0,0) address is 0x200.
- Assert rst_n=0 at (h=4,v=1) for 3 clocks -> outputs go to reset values immediately. After release, frame_start pulses on the first clock and the first visible pixel is at address 0.
